memory_stage: RTL and testbench

- Memory stage of the 5-stage core. It consumes the alu_mem buffer outputs and performs data-memory load/store and stack push/pop.
- It also performs the two-cycle 32-bit PC push/pop used by call/ret/int, and owns the stack pointer.
- Outputs are registered, so the block also acts as the mem/wb pipeline buffer feeding write-back and the fetch PC-select path.

---
 rtl/memory_stage_pkg.sv | 33 +++
 rtl/memory_stage_if.sv | 35 +++
 rtl/memory_stage_data_mem.sv | 24 ++
 rtl/memory_stage.sv | 145 ++++++++++++++
 tb/tb_memory_stage.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types and constants for the memory stage: control bit indices,
// FSM states and the registered mem/wb payload.
package memory_stage_pkg;

  localparam int unsigned MEM_W  = 6;
  localparam int unsigned WB_W   = 4;
  localparam int unsigned FLAG_W = 4;
  localparam int unsigned PC_W   = 32;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RDST_W = 3;

  localparam int unsigned MEM_READ_B  = 0;
  localparam int unsigned MEM_WRITE_B = 1;
  localparam int unsigned PUSH_B      = 2;
  localparam int unsigned POP_B       = 3;
  localparam int unsigned WIDE_B      = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WIDE2 = 1'b1
  } state_t;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [RDST_W-1:0] rdst;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem_data;
    logic [PC_W-1:0]   pc;
    logic              pc_load;
    logic [FLAG_W-1:0] flag;
  } mem_wb_t;

endpackage

// File: rtl/memory_stage_if.sv
// Bus between the alu/mem buffer, the memory stage and the write-back/fetch consumers.
interface memory_stage_if #(
  parameter int unsigned ADDR_W = 11
);
  import memory_stage_pkg::*;

  logic [MEM_W-1:0]  i_Mem;
  logic [WB_W-1:0]   i_WB;
  logic [PC_W-1:0]   i_pc;
  logic [RDST_W-1:0] i_Rdst;
  logic [DATA_W-1:0] i_alu;
  logic [DATA_W-1:0] i_read_data1;
  logic [FLAG_W-1:0] i_flag;

  logic              o_stall;
  logic [WB_W-1:0]   o_WB;
  logic [RDST_W-1:0] o_Rdst;
  logic [DATA_W-1:0] o_alu;
  logic [DATA_W-1:0] o_mem_data;
  logic [PC_W-1:0]   o_pc;
  logic              o_pc_load;
  logic [FLAG_W-1:0] o_flag;
  logic [ADDR_W-1:0] o_sp;

  modport master (
    output i_Mem, i_WB, i_pc, i_Rdst, i_alu, i_read_data1, i_flag,
    input  o_stall, o_WB, o_Rdst, o_alu, o_mem_data, o_pc, o_pc_load, o_flag, o_sp
  );

  modport slave (
    input  i_Mem, i_WB, i_pc, i_Rdst, i_alu, i_read_data1, i_flag,
    output o_stall, o_WB, o_Rdst, o_alu, o_mem_data, o_pc, o_pc_load, o_flag, o_sp
  );

endinterface

// File: rtl/memory_stage_data_mem.sv
// Single-port data memory: synchronous write, asynchronous read, contents not reset.
module memory_stage_data_mem
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// Memory stage: data load/store, stack push/pop, two-cycle 32-bit PC push/pop,
// stack pointer ownership and the registered mem/wb buffer.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned SP_RST = 2 ** ADDR_W - 1
) (
  input  logic         clk,
  input  logic         rst,
  memory_stage_if.slave bus
);

  localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RST);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d, sp_inc, sp_dec;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              wide_pop_q, wide_pop_d;
  mem_wb_t           out_q, out_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic rd, wr, push, pop, wide, stack_ok, wide_ok, bubble, stall_c;
  logic unused_rsvd;

  assign rd   = bus.i_Mem[MEM_READ_B];
  assign wr   = bus.i_Mem[MEM_WRITE_B];
  assign push = bus.i_Mem[PUSH_B];
  assign pop  = bus.i_Mem[POP_B];
  assign wide = bus.i_Mem[WIDE_B];
  assign unused_rsvd = bus.i_Mem[MEM_W-1];

  assign stack_ok = push ^ pop;
  assign wide_ok  = wide & stack_ok & ~rd & ~wr;
  assign bubble   = (bus.i_Mem[WIDE_B:0] == '0) && (bus.i_WB == '0);
  assign sp_inc   = sp_q + ADDR_W'(1);
  assign sp_dec   = sp_q - ADDR_W'(1);

  memory_stage_data_mem #(.ADDR_W(ADDR_W)) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Memory port steering; a legal stack op owns the port over a plain load/store.
  always_comb begin
    mem_addr  = bus.i_alu[ADDR_W-1:0];
    mem_we    = wr;
    mem_wdata = bus.i_read_data1;
    if (state_q == WIDE2) begin
      mem_addr  = wide_pop_q ? sp_inc : sp_q;
      mem_we    = ~wide_pop_q;
      mem_wdata = bus.i_pc[DATA_W-1:0];
    end else if (stack_ok) begin
      mem_addr  = pop ? sp_inc : sp_q;
      mem_we    = push;
      mem_wdata = wide_ok ? bus.i_pc[PC_W-1:DATA_W] : bus.i_read_data1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sp_q       <= SP_INIT;
      lo_q       <= '0;
      wide_pop_q <= 1'b0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      sp_q       <= sp_d;
      lo_q       <= lo_d;
      wide_pop_q <= wide_pop_d;
      out_q      <= out_d;
    end
  end

  // Next state, stack pointer and next mem/wb payload.
  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    lo_d         = lo_q;
    wide_pop_d   = wide_pop_q;
    stall_c      = 1'b0;
    out_d        = '0;
    out_d.wb     = bus.i_WB;
    out_d.rdst   = bus.i_Rdst;
    out_d.alu    = bus.i_alu;
    out_d.flag   = bus.i_flag;

    case (state_q)
      IDLE: begin
        if (wide_ok) begin
          // First half of a PC transfer: upstream holds, downstream sees a bubble.
          stall_c    = rst;
          out_d      = '0;
          state_d    = WIDE2;
          wide_pop_d = pop;
          if (push) begin
            sp_d = sp_dec;
          end else begin
            sp_d = sp_inc;
            lo_d = mem_rdata;
          end
        end else if (stack_ok) begin
          if (push) begin
            sp_d = sp_dec;
          end else begin
            sp_d           = sp_inc;
            out_d.mem_data = mem_rdata;
          end
        end else if (rd) begin
          out_d.mem_data = mem_rdata;
        end
        if (bubble) out_d = '0;
      end
      WIDE2: begin
        state_d = IDLE;
        if (wide_pop_q) begin
          sp_d          = sp_inc;
          out_d.pc      = {mem_rdata, lo_q};
          out_d.pc_load = 1'b1;
        end else begin
          sp_d = sp_dec;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_stall    = stall_c;
  assign bus.o_WB       = out_q.wb;
  assign bus.o_Rdst     = out_q.rdst;
  assign bus.o_alu      = out_q.alu;
  assign bus.o_mem_data = out_q.mem_data;
  assign bus.o_pc       = out_q.pc;
  assign bus.o_pc_load  = out_q.pc_load;
  assign bus.o_flag     = out_q.flag;
  assign bus.o_sp       = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: directed ops push expected mem/wb outputs,
// a monitor pops and compares one entry per clock.
module tb_memory_stage;
  import memory_stage_pkg::*;

  localparam int unsigned AW = 11;
  localparam logic [5:0] M_RD   = 6'h01;
  localparam logic [5:0] M_WR   = 6'h02;
  localparam logic [5:0] M_PUSH = 6'h04;
  localparam logic [5:0] M_POP  = 6'h08;
  localparam logic [5:0] M_WIDE = 6'h10;

  typedef struct {
    string       tag;
    logic [87:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  memory_stage_if #(.ADDR_W(AW)) bus ();

  memory_stage #(.ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [5:0] m, input logic [3:0] wb,
                     input logic [2:0] rd, input logic [15:0] alu, input logic [15:0] d1,
                     input logic [31:0] pc, input logic [3:0] fl, input logic pass,
                     input logic [15:0] e_md, input logic [31:0] e_pc, input logic e_pl,
                     input logic [10:0] e_sp, input logic e_st);
    exp_t e;
    @(negedge clk);
    bus.i_Mem        = m;
    bus.i_WB         = wb;
    bus.i_Rdst       = rd;
    bus.i_alu        = alu;
    bus.i_read_data1 = d1;
    bus.i_pc         = pc;
    bus.i_flag       = fl;
    e.tag = tag;
    e.v   = {pass ? wb : 4'h0, pass ? rd : 3'h0, pass ? alu : 16'h0, e_md, e_pc, e_pl,
             pass ? fl : 4'h0, e_sp, e_st};
    sb.push_back(e);
  endtask

  initial begin : monitor
    logic        st_s;
    logic [87:0] act;
    exp_t        e;
    forever begin
      @(negedge clk);
      #3;
      st_s = bus.o_stall;
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.o_WB, bus.o_Rdst, bus.o_alu, bus.o_mem_data, bus.o_pc, bus.o_pc_load,
               bus.o_flag, bus.o_sp, st_s};
        total++;
        if (act !== e.v) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.tag, act, e.v);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    bus.i_Mem = '0; bus.i_WB = '0; bus.i_pc = '0; bus.i_Rdst = '0;
    bus.i_alu = '0; bus.i_read_data1 = '0; bus.i_flag = '0;
    #2 rst = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_fields", 64'({bus.o_WB, bus.o_Rdst, bus.o_alu, bus.o_mem_data, bus.o_pc_load,
                          bus.o_flag}), 64'h0);
    chk("rst_pc", 64'(bus.o_pc), 64'h0);
    chk("rst_sp", 64'(bus.o_sp), 64'h7FF);
    chk("rst_stall", 64'(bus.o_stall), 64'h0);
    @(negedge clk);
    rst = 1'b1;

    //   tag          mem            wb    rd    alu       d1        pc            fl    pass  md        pc            pl    sp       st
    cyc("store5",     M_WR,          4'h0, 3'd0, 16'h0005, 16'hBEEF, 32'h0,        4'h0, 1'b1, 16'h0000, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("load5",      M_RD,          4'h2, 3'd1, 16'h0005, 16'h0000, 32'h0,        4'h0, 1'b1, 16'hBEEF, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("rdwr5",      M_RD | M_WR,   4'h2, 3'd1, 16'h0005, 16'h1111, 32'h0,        4'h1, 1'b1, 16'hBEEF, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("load5b",     M_RD,          4'h2, 3'd1, 16'h0005, 16'h0000, 32'h0,        4'h0, 1'b1, 16'h1111, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("bubble",     6'h00,         4'h0, 3'd7, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 4'hF, 1'b0, 16'h0000, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("push1",      M_PUSH,        4'h0, 3'd0, 16'h0000, 16'h1234, 32'h0,        4'h0, 1'b1, 16'h0000, 32'h0,        1'b0, 11'h7FE, 1'b0);
    cyc("push2",      M_PUSH,        4'h0, 3'd0, 16'h0000, 16'h5678, 32'h0,        4'h0, 1'b1, 16'h0000, 32'h0,        1'b0, 11'h7FD, 1'b0);
    cyc("pop1",       M_POP,         4'h2, 3'd4, 16'h0000, 16'h0000, 32'h0,        4'h0, 1'b1, 16'h5678, 32'h0,        1'b0, 11'h7FE, 1'b0);
    cyc("pop2",       M_POP,         4'h2, 3'd4, 16'h0000, 16'h0000, 32'h0,        4'h0, 1'b1, 16'h1234, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("pushpop",    M_PUSH | M_POP, 4'hF, 3'd3, 16'h0009, 16'hDEAD, 32'h0,       4'h4, 1'b1, 16'h0000, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("load7ff",    M_RD,          4'h2, 3'd1, 16'h07FF, 16'h0000, 32'h0,        4'h0, 1'b1, 16'h1234, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("wpush_hi",   M_PUSH | M_WIDE, 4'h0, 3'd5, 16'h0042, 16'h0000, 32'hAABBCCDD, 4'h2, 1'b0, 16'h0000, 32'h0,      1'b0, 11'h7FE, 1'b1);
    cyc("wpush_lo",   M_PUSH | M_WIDE, 4'h0, 3'd5, 16'h0042, 16'h0000, 32'hAABBCCDD, 4'h2, 1'b1, 16'h0000, 32'h0,      1'b0, 11'h7FD, 1'b0);
    cyc("ld_hi",      M_RD,          4'h2, 3'd1, 16'h07FF, 16'h0000, 32'h0,        4'h0, 1'b1, 16'hAABB, 32'h0,        1'b0, 11'h7FD, 1'b0);
    cyc("ld_lo",      M_RD,          4'h2, 3'd1, 16'h07FE, 16'h0000, 32'h0,        4'h0, 1'b1, 16'hCCDD, 32'h0,        1'b0, 11'h7FD, 1'b0);
    cyc("wpop_1",     M_POP | M_WIDE, 4'h0, 3'd2, 16'h0000, 16'h0000, 32'h0,       4'h0, 1'b0, 16'h0000, 32'h0,        1'b0, 11'h7FE, 1'b1);
    cyc("wpop_2",     M_POP | M_WIDE, 4'h0, 3'd2, 16'h0000, 16'h0000, 32'h0,       4'h0, 1'b1, 16'h0000, 32'hAABBCCDD, 1'b1, 11'h7FF, 1'b0);
    cyc("pcload_end", 6'h00,         4'h0, 3'd0, 16'h0000, 16'h0000, 32'h0,        4'h0, 1'b0, 16'h0000, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("wide_rd",    M_RD | M_WIDE, 4'h2, 3'd1, 16'h07FF, 16'h0000, 32'h0,        4'h0, 1'b1, 16'hAABB, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("store0",     M_WR,          4'h0, 3'd0, 16'h0000, 16'h0077, 32'h0,        4'h0, 1'b1, 16'h0000, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("pop_wrap",   M_POP,         4'h2, 3'd6, 16'h0000, 16'h0000, 32'h0,        4'h0, 1'b1, 16'h0077, 32'h0,        1'b0, 11'h000, 1'b0);
    cyc("push_wrap",  M_PUSH,        4'h0, 3'd0, 16'h0000, 16'h0001, 32'h0,        4'h0, 1'b1, 16'h0000, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("load0",      M_RD,          4'h2, 3'd1, 16'h0000, 16'h0000, 32'h0,        4'h0, 1'b1, 16'h0001, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("wpop_rst1",  M_POP | M_WIDE, 4'h0, 3'd2, 16'h0000, 16'h0000, 32'h0,       4'h0, 1'b0, 16'h0000, 32'h0,        1'b0, 11'h000, 1'b1);

    // Reset lands while the wide pop sits in its second cycle.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst2_fields", 64'({bus.o_WB, bus.o_Rdst, bus.o_alu, bus.o_mem_data, bus.o_pc_load,
                           bus.o_flag}), 64'h0);
    chk("rst2_pc", 64'(bus.o_pc), 64'h0);
    chk("rst2_sp", 64'(bus.o_sp), 64'h7FF);
    chk("rst2_stall", 64'(bus.o_stall), 64'h0);
    @(posedge clk);
    #2;
    chk("rst2_pc_load", 64'(bus.o_pc_load), 64'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_idle_stall", 64'(bus.o_stall), 64'h1);
    bus.i_Mem = '0;
    #1;
    chk("rst2_bubble_stall", 64'(bus.o_stall), 64'h0);

    cyc("post_rst",   6'h00,         4'h0, 3'd0, 16'h0000, 16'h0000, 32'h0,        4'h0, 1'b0, 16'h0000, 32'h0,        1'b0, 11'h7FF, 1'b0);
    cyc("post_load0", M_RD,          4'h2, 3'd1, 16'h0000, 16'h0000, 32'h0,        4'h0, 1'b1, 16'h0001, 32'h0,        1'b0, 11'h7FF, 1'b0);

    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
